reg_file_cmd_ctrl: RTL and testbench
====================================

# reg_file_cmd_ctrl

Command initiator for the register file. It parses the UART receive byte stream into register write and read transactions and drives the register file's RdEn/WrEn/Address/WrData port. It captures the returned RdData/RdData_Valid and hands the read byte to the UART transmitter. It sits between the UART RX/TX and the register file in the control system.

## Interface
- Add_Bus, 4: register file address width; the low Add_Bus bits of the address byte are used.
- Width, 8: data and byte width.
- WR_CMD, 8'hAA: write opcode; frame is opcode, address, data.
- RD_CMD, 8'hBB: read opcode; frame is opcode, address.
- RD_TIMEOUT, 15: maximum cycles spent in RD_WAIT before abandoning a read.
- ERR_BYTE, 8'hEE: byte transmitted on read timeout.

Ports:
- CLK  in  1  single system clock; all logic on its rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_P_Data  in  Width  received byte; valid only while RX_D_VLD=1.
- RX_D_VLD  in  1  one-cycle pulse per received byte.
- RdData  in  Width  register file read data.
- RdData_Valid  in  1  register file read-data strobe.
- TX_Busy  in  1  UART TX busy.
- Address  out  Add_Bus  register file address.
- WrData  out  Width  register file write data.
- WrEn  out  1  register file write enable, one-cycle pulse.
- RdEn  out  1  register file read enable, one-cycle pulse.
- TX_P_Data  out  Width  byte to transmit.
- TX_D_VLD  out  1  transmit request.
- Cmd_Err  out  1  one-cycle pulse on an unknown opcode.

## Operation
- States: IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_WAIT, TX_SEND.
- IDLE, on an RX_D_VLD byte:
  - WR_CMD goes to WR_ADDR.
  - RD_CMD goes to RD_ADDR.
  - Any other byte pulses Cmd_Err for one cycle and stays in IDLE.
- Write path:
  - WR_ADDR: on a byte, latch Address = byte[Add_Bus-1:0] and go to WR_DATA.
  - WR_DATA: on a byte, latch WrData and go to WR_EXEC.
  - WR_EXEC: WrEn=1 for exactly one cycle, then IDLE.
- Read path:
  - RD_ADDR: on a byte, latch Address and go to RD_EXEC.
  - RD_EXEC: RdEn=1 for exactly one cycle, go to RD_WAIT, clear the timeout counter.
  - RD_WAIT, on RdData_Valid=1: latch RdData into TX_P_Data and go to TX_WAIT.
  - RD_WAIT, when the counter reaches RD_TIMEOUT with no RdData_Valid: load ERR_BYTE into TX_P_Data and go to TX_WAIT.
  - RdData_Valid arriving outside RD_WAIT is ignored.
- Transmit path:
  - TX_WAIT: stay while TX_Busy=1; go to TX_SEND once TX_Busy=0.
  - TX_SEND: TX_D_VLD=1 and TX_P_Data held stable until TX_Busy=1 is sampled, then IDLE.
- Address bytes with upper bits set are truncated to the low Add_Bus bits, with no error.
- RX bytes arriving in WR_EXEC, RD_EXEC, RD_WAIT, TX_WAIT or TX_SEND are dropped; no queuing, no Cmd_Err.
- RdEn and WrEn are never high in the same cycle.
- Address and WrData hold their last value between transactions.
- RST=1 in any state, mid-frame included:
  - next state IDLE;
  - all outputs, including Address, WrData and TX_P_Data, cleared to 0;
  - timeout counter cleared.
- A partially received frame is discarded on reset.

## Timing
- Reset value of every output: 0.
- Write: data byte RX_D_VLD at cycle N gives WrEn=1 at N+1 only; Address and WrData stable from N+1.
- Read: address byte at cycle N gives RdEn=1 at N+1.
  - The register file returns RdData_Valid at N+2.
  - RdData is latched at N+2; state is TX_WAIT at N+3.
- Timeout: RD_WAIT is entered at N+2. With no RdData_Valid, the exit to TX_WAIT occurs RD_TIMEOUT cycles after RD_WAIT entry.
- TX_D_VLD rises at the earliest one cycle after TX_Busy=0 is observed in TX_WAIT. It falls the cycle after TX_Busy=1 is sampled.
- Back-to-back frames: a new opcode is accepted on the first cycle back in IDLE.

## Test plan
- Write: bytes AA,05,3C → one WrEn pulse with Address=5, WrData=3C, RdEn never high, TX_D_VLD stays 0.
- Read: AA,02,21 then BB,02 with a register file model (one-cycle latency) → RdEn pulse with Address=2, then TX_D_VLD with TX_P_Data=21, held until TX_Busy=1.
- Timeout: BB,07 with RdData_Valid never asserted → after RD_TIMEOUT cycles TX_P_Data=EE, TX_D_VLD=1.
- Bad opcode and truncation: byte 5A in IDLE → Cmd_Err one-cycle pulse, no enables. Then AA,F3,11 → WrEn with Address=3, WrData=11.
- TX backpressure and dropped bytes: TX_Busy=1 during a read response → TX_D_VLD stays 0 until TX_Busy falls. Extra RX bytes sent during TX_WAIT are dropped, with no WrEn/RdEn/Cmd_Err.
- Reset mid-frame: AA,04, then RST=1 for one cycle, then 09 → no WrEn, 09 treated as an opcode (Cmd_Err pulse), all outputs 0 immediately after reset.

Source files
------------

// File: rtl/reg_file_cmd_ctrl.sv
// reg_file_cmd_ctrl: parses UART RX bytes into register-file write/read frames and returns read bytes to UART TX
module reg_file_cmd_ctrl #(
  parameter int               Add_Bus    = 4,
  parameter int               Width      = 8,
  parameter logic [Width-1:0] WR_CMD     = 8'hAA,
  parameter logic [Width-1:0] RD_CMD     = 8'hBB,
  parameter int               RD_TIMEOUT = 15,
  parameter logic [Width-1:0] ERR_BYTE   = 8'hEE
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [Width-1:0]   RX_P_Data,
  input  logic               RX_D_VLD,
  input  logic [Width-1:0]   RdData,
  input  logic               RdData_Valid,
  input  logic               TX_Busy,
  output logic [Add_Bus-1:0] Address,
  output logic [Width-1:0]   WrData,
  output logic               WrEn,
  output logic               RdEn,
  output logic [Width-1:0]   TX_P_Data,
  output logic               TX_D_VLD,
  output logic               Cmd_Err
);
  localparam int CW = $clog2(RD_TIMEOUT + 1);
  typedef enum logic [3:0] {IDLE, WR_ADDR, WR_DATA, WR_EXEC, RD_ADDR, RD_EXEC, RD_WAIT, TX_WAIT, TX_SEND} state_t;
  state_t state, next;
  logic [CW-1:0] cnt;
  logic timeout;
  // exit RD_WAIT exactly RD_TIMEOUT cycles after entering it
  assign timeout = cnt == CW'(RD_TIMEOUT - 1);
  always_comb begin
    next = state;
    WrEn = state == WR_EXEC;
    RdEn = state == RD_EXEC;
    TX_D_VLD = state == TX_SEND;
    case (state)
      IDLE:    if (RX_D_VLD) next = RX_P_Data == WR_CMD ? WR_ADDR : RX_P_Data == RD_CMD ? RD_ADDR : IDLE;
      WR_ADDR: if (RX_D_VLD) next = WR_DATA;
      WR_DATA: if (RX_D_VLD) next = WR_EXEC;
      WR_EXEC: next = IDLE;
      RD_ADDR: if (RX_D_VLD) next = RD_EXEC;
      RD_EXEC: next = RD_WAIT;
      RD_WAIT: if (RdData_Valid || timeout) next = TX_WAIT;
      TX_WAIT: if (!TX_Busy) next = TX_SEND;
      TX_SEND: if (TX_Busy) next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      Address <= '0;
      WrData <= '0;
      TX_P_Data <= '0;
      Cmd_Err <= 1'b0;
      cnt <= '0;
    end else begin
      state <= next;
      Cmd_Err <= state == IDLE && RX_D_VLD && RX_P_Data != WR_CMD && RX_P_Data != RD_CMD;
      cnt <= state == RD_WAIT ? cnt + 1'b1 : '0;
      if ((state == WR_ADDR || state == RD_ADDR) && RX_D_VLD) Address <= RX_P_Data[Add_Bus-1:0];
      if (state == WR_DATA && RX_D_VLD) WrData <= RX_P_Data;
      if (state == RD_WAIT) TX_P_Data <= RdData_Valid ? RdData : timeout ? ERR_BYTE : TX_P_Data;
    end
  end
endmodule

// File: tb/tb_reg_file_cmd_ctrl.sv
// tb_reg_file_cmd_ctrl: randomized frame-level bench with register-file and UART models
module tb_reg_file_cmd_ctrl;
  localparam int TO = 15;
  logic       CLK = 0, RST = 1, RX_D_VLD = 0, TX_Busy = 0;
  logic [7:0] RX_P_Data = 0;
  logic       RdData_Valid;
  logic [7:0] RdData;
  logic [3:0] Address;
  logic [7:0] WrData, TX_P_Data;
  logic       WrEn, RdEn, TX_D_VLD, Cmd_Err;
  int n_chk = 0, n_pass = 0;
  int wr_pulses = 0, rd_pulses = 0, err_pulses = 0, tx_cycles = 0;
  logic [7:0] exp_mem [16];
  logic [7:0] rf_mem [16];
  logic       rf_vld = 0, mute = 0, spur = 0;
  logic [7:0] rf_data = 0, junk = 0;

  reg_file_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_Data(RX_P_Data), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .TX_Busy(TX_Busy),
    .Address(Address), .WrData(WrData), .WrEn(WrEn), .RdEn(RdEn),
    .TX_P_Data(TX_P_Data), .TX_D_VLD(TX_D_VLD), .Cmd_Err(Cmd_Err)
  );

  always #5 CLK = ~CLK;

  // register file with one-cycle read latency; spur injects stray strobes with junk data
  assign RdData_Valid = rf_vld | spur;
  assign RdData = spur ? junk : rf_data;
  always @(posedge CLK) begin
    if (WrEn) rf_mem[Address] <= WrData;
    rf_vld <= RdEn && !mute;
    rf_data <= rf_mem[Address];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge CLK) if (!RST) begin
    if (WrEn) wr_pulses++;
    if (RdEn) rd_pulses++;
    if (Cmd_Err) err_pulses++;
    if (TX_D_VLD) tx_cycles++;
    check("wr_rd_excl", WrEn & RdEn, 0);
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send(input logic [7:0] b);
    RX_P_Data = b;
    RX_D_VLD = 1;
    tick();
    RX_D_VLD = 0;
    RX_P_Data = 8'($urandom);
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    int w0, r0, e0, t0;
    w0 = wr_pulses; r0 = rd_pulses; e0 = err_pulses; t0 = tx_cycles;
    gap(); send(8'hAA); gap(); send(a); gap(); send(d);
    check("wr_en", WrEn, 1);
    check("wr_addr", Address, a[3:0]);
    check("wr_data", WrData, d);
    exp_mem[a[3:0]] = d;
    tick();
    check("wr_en_off", WrEn, 0);
    check("wr_hold_addr", Address, a[3:0]);
    check("wr_hold_data", WrData, d);
    check("wr_pulses", wr_pulses - w0, 1);
    check("wr_no_rd", rd_pulses - r0, 0);
    check("wr_no_err", err_pulses - e0, 0);
    check("wr_no_tx", tx_cycles - t0, 0);
  endtask

  // to: suppress read data; b: extra busy cycles in TX_WAIT; h: cycles before UART accepts
  task automatic do_read(input logic [7:0] a, input bit to, input int b, input int h);
    int w0, r0, e0, tw, s;
    logic [7:0] exp;
    w0 = wr_pulses; r0 = rd_pulses; e0 = err_pulses;
    gap(); send(8'hBB); gap(); send(a);
    check("rd_en", RdEn, 1);
    check("rd_addr", Address, a[3:0]);
    mute = to;
    exp = to ? 8'hEE : exp_mem[a[3:0]];
    tw = to ? 2 + TO : 3;
    s = tw + b + 1 + h;
    for (int c = 2; c <= s + 1; c++) begin
      tick();
      check(to ? "to_tx_vld" : "rd_tx_vld", TX_D_VLD, c > tw + b && c <= s);
      if (c > tw + b && c <= s) check(to ? "to_tx_data" : "rd_tx_data", TX_P_Data, exp);
      if (c == 2) check("rd_en_off", RdEn, 0);
      TX_Busy = c < tw + b || c == s;
      spur = c >= tw && $urandom_range(0, 3) == 0;
      junk = 8'($urandom);
      RX_D_VLD = c <= s && $urandom_range(0, 2) == 0;
      RX_P_Data = $urandom_range(0, 1) ? ($urandom_range(0, 1) ? 8'hAA : 8'hBB) : 8'($urandom);
    end
    RX_D_VLD = 0; spur = 0; mute = 0; TX_Busy = 0;
    check("rd_pulses", rd_pulses - r0, 1);
    check("rd_no_wr", wr_pulses - w0, 0);
    check("rd_no_err", err_pulses - e0, 0);
  endtask

  task automatic do_bad(input logic [7:0] v);
    int w0, r0;
    w0 = wr_pulses; r0 = rd_pulses;
    gap(); send(v);
    check("cmd_err", Cmd_Err, 1);
    tick();
    check("cmd_err_off", Cmd_Err, 0);
    check("bad_no_en", (wr_pulses - w0) + (rd_pulses - r0), 0);
  endtask

  initial begin
    logic [7:0] v;
    int w0;
    repeat (2) tick();
    check("rst_addr", Address, 0);
    check("rst_wrdata", WrData, 0);
    check("rst_txdata", TX_P_Data, 0);
    check("rst_en", {WrEn, RdEn, TX_D_VLD, Cmd_Err}, 0);
    RST = 0;
    tick();
    for (int i = 0; i < 16; i++) do_write(8'(i), 8'($urandom));
    do_write(8'h05, 8'h3C);
    do_write(8'h02, 8'h21);
    do_read(8'h02, 0, 0, 0);
    do_read(8'h07, 1, 0, 1);
    do_bad(8'h5A);
    do_write(8'hF3, 8'h11);
    do_read(8'h03, 0, 3, 2);
    do_read(8'h02, 0, 1, 0);
    w0 = wr_pulses;
    gap(); send(8'hAA); send(8'h04);
    RST = 1;
    tick();
    RST = 0;
    check("mid_rst_addr", Address, 0);
    check("mid_rst_wrdata", WrData, 0);
    check("mid_rst_txdata", TX_P_Data, 0);
    check("mid_rst_en", {WrEn, RdEn, TX_D_VLD, Cmd_Err}, 0);
    send(8'h09);
    check("mid_rst_err", Cmd_Err, 1);
    tick();
    check("mid_rst_no_wr", wr_pulses - w0, 0);
    repeat (80) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: do_write(8'($urandom), 8'($urandom));
        4, 5, 6:    do_read(8'($urandom), 0, $urandom_range(0, 4), $urandom_range(0, 2));
        7:          do_read(8'($urandom), 1, $urandom_range(0, 2), $urandom_range(0, 2));
        default: begin
          v = 8'($urandom);
          if (v == 8'hAA || v == 8'hBB) v = 8'h00;
          do_bad(v);
        end
      endcase
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
